// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, default sizes and address-width helper for the register file
package regfile_pkg;
  typedef enum logic {RF_INIT, RF_READY} rf_state_e;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF = 2;
  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_if.sv
// regfile_if: read/write/alloc/debug bundle between decode-stage clients and regfile_mp
interface regfile_if import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = NRD_DEF
) ();
  localparam int AW = rf_aw(NREGS);
  logic init_done;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic alloc_en;
  logic [AW-1:0] alloc_addr;
  logic [AW-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_data;
  modport master (
    input init_done, rd_data, rd_busy, dbg_data,
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, dbg_addr
  );
  modport slave (
    output init_done, rd_data, rd_busy, dbg_data,
    input rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, dbg_addr
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, alloc beats writeback; REGFILE_BYPASS_EN masks lookups hit by a same-cycle write
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = NRD_DEF,
  localparam int AW = rf_aw(NREGS)
) (
  input  logic clk,
  input  logic rst,
  input  logic set_en,
  input  logic [AW-1:0] set_addr,
  input  logic clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0] rd_busy
);
  logic [NREGS-1:0] busy, busy_nx;
  always_comb begin
    busy_nx = busy;
    if (clr_en) busy_nx[clr_addr] = 1'b0;
    if (set_en) busy_nx[set_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else busy <= busy_nx;
  end
  for (genvar g = 0; g < NRD; g++) begin : lk_g
    logic [AW-1:0] a;
    assign a = rd_addr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rd_busy[g] = busy[a] && !(clr_en && clr_addr == a);
`else
    assign rd_busy[g] = busy[a];
`endif
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with post-reset zero sweep, busy scoreboard and optional REGFILE_BYPASS_EN write bypass
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = NRD_DEF,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  regfile_if.slave bus
);
  localparam int AW = rf_aw(NREGS);
  rf_state_e state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [XLEN-1:0] mem [NREGS];
  logic ready, wr_ok, alloc_ok;
  logic [NRD-1:0] busy;
  logic [NRD*XLEN-1:0] rd_data;
  assign ready = state == RF_READY;
  assign wr_ok = ready && bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
  assign alloc_ok = ready && bus.alloc_en && !(ZERO_REG != 0 && bus.alloc_addr == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_INIT;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = (state == RF_INIT && cnt == AW'(NREGS - 1)) ? RF_READY : state;
    cnt_nx = (state == RF_INIT) ? cnt + AW'(1) : cnt;
  end
  always_ff @(posedge clk) begin
    if (state == RF_INIT) mem[cnt] <= '0;
    else if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  end
  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(alloc_ok),
    .set_addr(bus.alloc_addr),
    .clr_en(wr_ok),
    .clr_addr(bus.wr_addr),
    .rd_addr(bus.rd_addr),
    .rd_busy(busy)
  );
  for (genvar g = 0; g < NRD; g++) begin : rd_g
    logic [AW-1:0] a;
    logic z;
    assign a = bus.rd_addr[g*AW +: AW];
    assign z = ZERO_REG != 0 && a == '0;
`ifdef REGFILE_BYPASS_EN
    assign rd_data[g*XLEN +: XLEN] = (!ready || z) ? '0 : (wr_ok && bus.wr_addr == a) ? bus.wr_data : mem[a];
`else
    assign rd_data[g*XLEN +: XLEN] = (!ready || z) ? '0 : mem[a];
`endif
  end
  assign bus.rd_data = rd_data;
  assign bus.rd_busy = ready ? busy : '0;
  assign bus.dbg_data = (!ready || (ZERO_REG != 0 && bus.dbg_addr == '0)) ? '0 : mem[bus.dbg_addr];
  assign bus.init_done = ready;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (ZERO_REG=1 and ZERO_REG=0 instances), expectations follow REGFILE_BYPASS_EN
module tb_regfile_mp;
  import regfile_pkg::*;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  regfile_if #(.XLEN(32), .NREGS(32), .NRD(2)) a ();
  regfile_if #(.XLEN(32), .NREGS(32), .NRD(2)) b ();
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut (.clk(clk), .rst(rst), .bus(a));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(0)) dut_z (.clk(clk), .rst(rst), .bus(b));
  assign b.rd_addr = a.rd_addr;
  assign b.wr_en = a.wr_en;
  assign b.wr_addr = a.wr_addr;
  assign b.wr_data = a.wr_data;
  assign b.alloc_en = a.alloc_en;
  assign b.alloc_addr = a.alloc_addr;
  assign b.dbg_addr = a.dbg_addr;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return a.rd_data[31:0];
      1: return a.rd_data[63:32];
      2: return a.dbg_data;
      3: return {31'b0, a.rd_busy[0]};
      4: return {31'b0, a.rd_busy[1]};
      5: return {31'b0, a.init_done};
      6: return b.rd_data[31:0];
      7: return {31'b0, b.rd_busy[0]};
      default: return '0;
    endcase
  endfunction
  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    q.push_back('{tag, sel, exp});
  endtask
  task automatic drain();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask
  task automatic set(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic ae,
                     input logic [4:0] aa, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] dbg);
    a.wr_en = we;
    a.wr_addr = wa;
    a.wr_data = wd;
    a.alloc_en = ae;
    a.alloc_addr = aa;
    a.rd_addr = {r1, r0};
    a.dbg_addr = dbg;
  endtask
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic ae,
                       input logic [4:0] aa, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] dbg);
    @(negedge clk);
    set(we, wa, wd, ae, aa, r0, r1, dbg);
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!a.init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, 32);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    set(0, 0, 0, 0, 0, 5, 5, 5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push("rst_init_done", 5, 0);
    push("rst_rd0", 0, 0);
    push("rst_dbg", 2, 0);
    drain();
    rst = 1'b0;
    wait_ready("sweep_len");
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 5'(i));
      push("dbg_zero", 2, 0);
      drain();
    end
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 5, 5, 5);
    push("x5_rd0", 0, 32'hDEADBEEF);
    push("x5_rd1", 1, 32'hDEADBEEF);
    push("x5_dbg", 2, 32'hDEADBEEF);
    drain();
    drive(1, 0, 32'h1234, 1, 0, 0, 5, 0);
    push("x0_rd0_now", 0, 0);
    push("x0_busy_now", 3, 0);
    push("x0_dbg_now", 2, 0);
    push("x5_rd1_keep", 1, 32'hDEADBEEF);
    drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("x0_rd0_next", 0, 0);
    push("x0_busy_next", 3, 0);
    push("nz_x0_rd0", 6, 32'h1234);
    push("nz_x0_busy", 7, 1);
    drain();
    drive(0, 0, 0, 1, 7, 7, 7, 0);
    push("x7_busy_alloc_cyc", 3, 0);
    drain();
    drive(1, 7, 32'hA5, 1, 7, 7, 7, 0);
    push("x7_busy_after_alloc", 3, BYP ? 0 : 1);
    push("x7_busy1_after_alloc", 4, BYP ? 0 : 1);
    push("x7_rd0_wr_alloc", 0, BYP ? 32'hA5 : 32'h0);
    drain();
    drive(1, 7, 32'h5A, 0, 0, 7, 7, 0);
    push("x7_busy_realloc", 3, BYP ? 0 : 1);
    push("x7_rd0_realloc", 0, BYP ? 32'h5A : 32'hA5);
    drain();
    drive(0, 0, 0, 0, 0, 7, 7, 7);
    push("x7_busy_cleared", 3, 0);
    push("x7_rd0_final", 0, 32'h5A);
    push("x7_dbg_final", 2, 32'h5A);
    drain();
    drive(1, 9, 32'hCAFE, 0, 0, 9, 5, 9);
    push("x9_rd0_same", 0, BYP ? 32'hCAFE : 32'h0);
    push("x9_busy_same", 3, 0);
    push("x9_dbg_same", 2, 0);
    push("x5_rd1_same", 1, 32'hDEADBEEF);
    drain();
    drive(0, 0, 0, 0, 0, 9, 9, 9);
    push("x9_rd0_next", 0, 32'hCAFE);
    push("x9_rd1_next", 1, 32'hCAFE);
    push("x9_dbg_next", 2, 32'hCAFE);
    drain();
    drive(0, 0, 0, 1, 11, 11, 11, 0);
    drive(0, 0, 0, 0, 0, 11, 11, 0);
    push("x11_busy", 3, 1);
    drain();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 11, 5);
    push("rst2_init_done", 5, 0);
    push("rst2_rd0", 0, 0);
    push("rst2_busy1", 4, 0);
    push("rst2_dbg", 2, 0);
    drain();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set(1, 3, 32'hFFFF, 1, 3, 3, 5, 3);
    rst = 1'b0;
    push("sweep_rd0_forced", 0, 0);
    push("sweep_busy_forced", 3, 0);
    drain();
    wait_ready("restart_len");
    set(0, 0, 0, 0, 0, 3, 5, 3);
    push("x3_dbg_swept", 2, 0);
    push("x3_rd0_swept", 0, 0);
    push("x3_busy_swept", 3, 0);
    push("x5_rd1_swept", 1, 0);
    push("nz_x3_busy", 7, 0);
    drain();
    drive(0, 0, 0, 0, 0, 11, 9, 9);
    push("x11_busy_cleared", 3, 0);
    push("x9_rd1_swept", 1, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
